// File: rtl/neuron_acc_pkg.sv
// Shared parameters and FSM encoding for the neuron dot-product accumulator.
`ifndef DataWidth
`define DataWidth 16
`endif

package neuron_acc_pkg;

  localparam int unsigned DataWidth       = `DataWidth;
  localparam int unsigned FracDefault     = 8;
  localparam int unsigned CntWidthDefault = 8;
  localparam int unsigned AccWidthDefault = 2 * DataWidth + CntWidthDefault;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_SAT   = 2'd2,
    ST_DRIVE = 2'd3
  } state_e;

endpackage

// File: rtl/neuron_acc_sat_round.sv
// Round-half-up, arithmetic shift by FRAC and saturate the accumulator
// to a signed DATA_WIDTH result.
module sat_round
  import neuron_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned FRAC       = FracDefault,
  parameter int unsigned ACC_WIDTH  = AccWidthDefault
) (
  input  logic [ACC_WIDTH-1:0]  acc,
  output logic [DATA_WIDTH-1:0] res_c
);

  // One guard bit so the rounding offset can never wrap the sum.
  localparam int unsigned SumWidth = ACC_WIDTH + 1;

  logic signed [SumWidth-1:0] sum_c;
  logic signed [SumWidth-1:0] shr_c;
  logic signed [SumWidth-1:0] max_c;
  logic signed [SumWidth-1:0] min_c;

  always_comb begin
    max_c                   = '0;
    max_c[DATA_WIDTH-2:0]   = '1;
    min_c                   = '1;
    min_c[DATA_WIDTH-2:0]   = '0;
    sum_c = SumWidth'($signed(acc)) + (SumWidth'(1) << (FRAC - 1));
    shr_c = sum_c >>> FRAC;
    res_c = shr_c[DATA_WIDTH-1:0];
    if (shr_c > max_c) begin
      res_c = max_c[DATA_WIDTH-1:0];
    end else if (shr_c < min_c) begin
      res_c = min_c[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/neuron_acc.sv
// Fixed-point dot-product accumulator: sums len signed products, rounds and
// saturates, then drives the shared activation bus for one cycle.
module neuron_acc
  import neuron_acc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth,
  parameter int unsigned FRAC       = FracDefault,
  parameter int unsigned CNT_WIDTH  = CntWidthDefault,
  parameter int unsigned ACC_WIDTH  = 2 * DATA_WIDTH + CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  len,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] in_weight,
  output logic                  in_ready,
  inout  logic [DATA_WIDTH-1:0] act,
  output logic                  rtm_en,
  output logic                  busy
);

  localparam int unsigned ProdWidth = 2 * DATA_WIDTH;

  state_e                       state_q, state_d;
  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]         cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]         len_q, len_d;
  logic [DATA_WIDTH-1:0]        result_q, result_d;
  logic                         in_ready_q, in_ready_d;
  logic                         rtm_en_q, rtm_en_d;
  logic                         busy_q, busy_d;
  logic                         drive_q, drive_d;

  logic signed [ProdWidth-1:0]  prod_c;
  logic [CNT_WIDTH-1:0]         cnt_inc_c;
  logic [DATA_WIDTH-1:0]        sat_res_c;

  sat_round #(
    .DATA_WIDTH (DATA_WIDTH),
    .FRAC       (FRAC),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_sat_round (
    .acc   (acc_q),
    .res_c (sat_res_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      len_q      <= '0;
      result_q   <= '0;
      in_ready_q <= 1'b0;
      rtm_en_q   <= 1'b0;
      busy_q     <= 1'b0;
      drive_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      result_q   <= result_d;
      in_ready_q <= in_ready_d;
      rtm_en_q   <= rtm_en_d;
      busy_q     <= busy_d;
      drive_q    <= drive_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    result_d  = result_q;
    prod_c    = ProdWidth'($signed(in_data)) * ProdWidth'($signed(in_weight));
    cnt_inc_c = CNT_WIDTH'(cnt_q + 1'b1);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d   = len;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = (len != '0) ? ST_ACC : ST_SAT;
        end
      end
      ST_ACC: begin
        if (in_valid && in_ready_q) begin
          acc_d = acc_q + ACC_WIDTH'(prod_c);
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == len_q) begin
            state_d = ST_SAT;
          end
        end
      end
      ST_SAT: begin
        result_d = sat_res_c;
        state_d  = ST_DRIVE;
      end
      ST_DRIVE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered from the next state so they align with state_q.
    in_ready_d = (state_d == ST_ACC);
    rtm_en_d   = (state_d == ST_DRIVE);
    drive_d    = (state_d == ST_DRIVE);
    busy_d     = (state_d != ST_IDLE);
  end

  assign in_ready = in_ready_q;
  assign rtm_en   = rtm_en_q;
  assign busy     = busy_q;
  assign act      = drive_q ? result_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_neuron_acc.sv
// Randomized self-checking bench for neuron_acc with a transaction-level model.
module tb_neuron_acc;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic [15:0] in_data;
  logic [15:0] in_weight;
  logic        in_ready;
  logic        rtm_en;
  logic        busy;
  wire  [15:0] act;

  // Weak pull-ups make an undriven bus read as all ones.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (act[i]);
  end

  neuron_acc dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_weight (in_weight),
    .in_ready  (in_ready),
    .act       (act),
    .rtm_en    (rtm_en),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          checks;
  int          failures;
  bit          chk_en;
  bit          exp_ready;
  bit          exp_busy;
  bit          exp_drive;
  logic [15:0] exp_act;
  logic [15:0] last_act;
  int          pulses;
  int          exp_pulses;
  bit          vq[$];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, a, e);
    end
  endtask

  task automatic set_exp(input bit r, input bit b, input bit d, input logic [15:0] a);
    exp_ready = r;
    exp_busy  = b;
    exp_drive = d;
    exp_act   = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Round half up at bit 8, then clamp to the signed 16-bit range.
  function automatic logic [15:0] ref_result(input longint s);
    longint r;
    r = (s + 64'sd128) >>> 8;
    if (r > 64'sd32767) r = 64'sd32767;
    else if (r < -64'sd32768) r = -64'sd32768;
    return 16'(r);
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom % 4)
      0:       return 16'h7FFF;
      1:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic bit next_valid(input int pct);
    if (vq.size() > 0) return vq.pop_front();
    return ($urandom % 100) < pct;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(in_ready), 32'(exp_ready));
      check("busy",     32'(busy),     32'(exp_busy));
      check("rtm_en",   32'(rtm_en),   32'(exp_drive));
      if (exp_drive) check("act", 32'(act), 32'(exp_act));
      else           check("act_z", 32'(act), 32'h0000_FFFF);
      if (rtm_en === 1'b1) begin
        pulses++;
        last_act = act;
      end
    end
  end

  // One dot product from the start cycle through DRIVE; rst_at>0 resets the
  // block in the cycle after the rst_at-th accepted term.
  task automatic run_op(input int n, input bit rnd, input logic [15:0] d0,
                        input logic [15:0] w0, input int pct, input bit hold,
                        input int rst_at, output logic [15:0] res);
    longint sum;
    int     acc;
    bit     v;
    sum = 0;
    acc = 0;
    res = 'x;
    start = 1'b1;
    len   = 8'(n);
    set_exp(0, 0, 0, '0);
    step();
    while (acc < n) begin
      set_exp(1, 1, 0, '0);
      start    = hold ? 1'b1 : 1'($urandom);
      len      = 8'($urandom);
      v        = next_valid(pct);
      in_valid = v;
      in_data   = rnd ? pick_operand() : (v ? d0 : 16'($urandom));
      in_weight = rnd ? pick_operand() : (v ? w0 : 16'($urandom));
      if (v) begin
        sum += longint'($signed(in_data)) * longint'($signed(in_weight));
        acc++;
      end
      step();
      if (rst_at > 0 && acc == rst_at) begin
        in_valid = 1'b0;
        rst      = 1'b1;
        start    = 1'b1;
        set_exp(acc < n, 1, 0, '0);
        step();
        rst   = 1'b0;
        start = 1'b0;
        set_exp(0, 0, 0, '0);
        return;
      end
    end
    in_valid = 1'b0;
    start    = hold ? 1'b1 : 1'($urandom);
    set_exp(0, 1, 0, '0);
    step();
    res = ref_result(sum);
    start = hold ? 1'b1 : 1'($urandom);
    set_exp(0, 1, 1, res);
    exp_pulses++;
    step();
    start = hold;
    set_exp(0, 0, 0, '0);
  endtask

  task automatic idle_cycles(input int k);
    start    = 1'b0;
    in_valid = 1'b0;
    set_exp(0, 0, 0, '0);
    for (int i = 0; i < k; i++) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] res;
    checks = 0; failures = 0; pulses = 0; exp_pulses = 0;
    chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; in_weight = '0;
    set_exp(0, 0, 0, '0);
    step();
    chk_en = 1'b1;
    step();
    // Reset must win over a simultaneous start.
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0; rst = 1'b0;
    idle_cycles(2);

    run_op(3, 0, 16'h0100, 16'h0200, 100, 0, 0, res);
    check("t030_model", 32'(res), 32'h0600);
    check("t030_act", 32'(last_act), 32'h0600);
    idle_cycles(1);

    run_op(2, 0, 16'h7FFF, 16'h7FFF, 100, 0, 0, res);
    check("t031_pos_act", 32'(last_act), 32'h7FFF);
    run_op(2, 0, 16'h8000, 16'h7FFF, 60, 0, 0, res);
    check("t031_neg_model", 32'(res), 32'h8000);
    check("t031_neg_act", 32'(last_act), 32'h8000);
    idle_cycles(1);

    run_op(0, 0, 16'h0, 16'h0, 100, 0, 0, res);
    check("t032_act", 32'(last_act), 32'h0000);
    idle_cycles(1);

    vq = '{1, 0, 0, 1, 1, 0, 1};
    run_op(4, 0, 16'h0080, 16'h0100, 100, 0, 0, res);
    check("t033_pattern_used", 32'(vq.size()), 32'd0);
    check("t033_act", 32'(last_act), 32'h0200);
    idle_cycles(1);

    run_op(4, 0, 16'h0100, 16'h0100, 100, 0, 2, res);
    idle_cycles(1);
    run_op(1, 0, 16'h0100, 16'h0100, 100, 0, 0, res);
    check("t034_act", 32'(last_act), 32'h0100);
    idle_cycles(1);
    run_op(2, 1, 16'h0, 16'h0, 80, 0, 2, res);
    idle_cycles(1);

    // Start held high across back-to-back operations.
    run_op(2, 1, 16'h0, 16'h0, 100, 1, 0, res);
    run_op(3, 1, 16'h0, 16'h0, 70, 1, 0, res);
    run_op(0, 0, 16'h0, 16'h0, 100, 0, 0, res);
    check("t035_len0_act", 32'(last_act), 32'h0000);
    idle_cycles(1);

    for (int t = 0; t < 40; t++) begin
      run_op(int'($urandom_range(0, 12)), 1, 16'h0, 16'h0, 70,
             1'($urandom % 4 == 0), 0, res);
      if ($urandom % 2) idle_cycles(int'($urandom_range(1, 3)));
    end
    idle_cycles(1);
    run_op(255, 0, 16'h7FFF, 16'h7FFF, 100, 0, 0, res);
    check("long_sat_act", 32'(last_act), 32'h7FFF);
    idle_cycles(3);

    check("rtm_pulse_count", 32'(pulses), 32'(exp_pulses));
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
